// File: rtl/i2c_merger_n_if.sv
// Master-side and downstream pad signals of the N-way I2C merger.
// The slave modport is the merger itself; master is the surrounding EMIO/pad logic.
interface i2c_merger_n_if #(
    parameter int NBUS = 2
);
    logic            scl_in;
    logic            sda_in_t;
    logic            sda_in_o;
    logic [NBUS-1:0] sda_i;
    logic [NBUS-1:0] scl_oe_o;
    logic [NBUS-1:0] sda_oe_o;

    modport master (
        output scl_in, sda_in_t, sda_i,
        input  sda_in_o, scl_oe_o, sda_oe_o
    );

    modport slave (
        input  scl_in, sda_in_t, sda_i,
        output sda_in_o, scl_oe_o, sda_oe_o
    );
endinterface

// File: rtl/i2c_merger_n.sv
// Fans one I2C master out to NBUS open-drain buses with an idle-only enable mask,
// START/STOP tracking and a hardware bus-clear sequencer for stuck SDA.
module i2c_merger_n #(
    parameter int              NBUS        = 2,
    parameter int              SYNC_STAGES = 2,
    parameter logic [NBUS-1:0] RESET_MASK  = {NBUS{1'b1}},
    parameter int              CLR_HALF    = 250,
    parameter int              CLR_PULSES  = 9
) (
    input  logic            clk_i,
    input  logic            rst_i,
    i2c_merger_n_if.slave   bus,
    input  logic [NBUS-1:0] mask_i,
    output logic [NBUS-1:0] mask_o,
    output logic            busy_o,
    input  logic            clr_req_i,
    output logic            clr_busy_o,
    output logic            clr_fail_o
);

    localparam int HW = $clog2(CLR_HALF);
    localparam int PW = $clog2(CLR_PULSES + 1);
    localparam logic [HW-1:0] HC_LAST = HW'(CLR_HALF - 1);
    localparam logic [PW-1:0] N_MAX   = PW'(CLR_PULSES);

    typedef enum logic [2:0] {IDLE, LO, HI, SA, SB, SC} state_t;

    state_t          state;
    logic [HW-1:0]   hc;
    logic [PW-1:0]   n;
    logic [NBUS-1:0] sync_q [SYNC_STAGES];
    logic [NBUS-1:0] sda_s;
    logic            scl_r;
    logic            sdat_r;
    logic            sdat_d;
    logic            all_hi;
    logic            start_det;
    logic            stop_det;
    logic            half_done;

    assign sda_s     = sync_q[SYNC_STAGES-1];
    assign all_hi    = &(sda_s | ~mask_o);
    assign start_det = scl_r & sdat_d & ~sdat_r;
    assign stop_det  = scl_r & ~sdat_d & sdat_r;
    assign half_done = (hc == HC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= bus.sda_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Outputs are loaded on state entry so the pads change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            hc           <= '0;
            n            <= '0;
            scl_r        <= 1'b1;
            sdat_r       <= 1'b1;
            sdat_d       <= 1'b1;
            mask_o       <= RESET_MASK;
            busy_o       <= 1'b0;
            clr_busy_o   <= 1'b0;
            clr_fail_o   <= 1'b0;
            bus.scl_oe_o <= '0;
            bus.sda_oe_o <= '0;
            bus.sda_in_o <= 1'b1;
        end else begin
            scl_r  <= bus.scl_in;
            sdat_r <= bus.sda_in_t;
            sdat_d <= sdat_r;

            if (state != IDLE) hc <= half_done ? '0 : hc + 1'b1;

            case (state)
                IDLE: begin
                    bus.scl_oe_o <= mask_o & ~{NBUS{scl_r}};
                    bus.sda_oe_o <= mask_o & ~{NBUS{sdat_r}};
                    bus.sda_in_o <= sdat_r & all_hi;
                    if (start_det)     busy_o <= 1'b1;
                    else if (stop_det) busy_o <= 1'b0;
                    if (!busy_o) mask_o <= mask_i;
                    if (clr_req_i && !busy_o) begin
                        state        <= LO;
                        hc           <= '0;
                        n            <= '0;
                        clr_busy_o   <= 1'b1;
                        clr_fail_o   <= 1'b0;
                        bus.scl_oe_o <= mask_o;
                        bus.sda_oe_o <= '0;
                        bus.sda_in_o <= 1'b1;
                    end
                end
                LO: begin
                    if (half_done) begin
                        state        <= HI;
                        bus.scl_oe_o <= '0;
                        n            <= n + 1'b1;
                    end
                end
                HI: begin
                    if (half_done) begin
                        if (all_hi) begin
                            state        <= SA;
                            bus.scl_oe_o <= mask_o;
                            bus.sda_oe_o <= mask_o;
                        end else if (n < N_MAX) begin
                            state        <= LO;
                            bus.scl_oe_o <= mask_o;
                        end else begin
                            state      <= IDLE;
                            clr_fail_o <= 1'b1;
                            clr_busy_o <= 1'b0;
                            busy_o     <= 1'b0;
                        end
                    end
                end
                SA: begin
                    if (half_done) begin
                        state        <= SB;
                        bus.scl_oe_o <= '0;
                    end
                end
                SB: begin
                    if (half_done) begin
                        state        <= SC;
                        bus.sda_oe_o <= '0;
                    end
                end
                SC: begin
                    if (half_done) begin
                        state      <= IDLE;
                        clr_busy_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_merger_n.sv
// Directed bench for i2c_merger_n: forwarding, readback latency, idle-only mask,
// bus clear success/failure, dropped requests and reset during a clear.
module tb_i2c_merger_n;

    localparam int NB = 3;
    localparam int CH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] mask_i;
    logic [NB-1:0] mask_o;
    logic          busy_o;
    logic          clr_req;
    logic          clr_busy;
    logic          clr_fail;
    logic          m_scl;
    logic          m_sdat;
    logic [NB-1:0] slave_low;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_merger_n_if #(.NBUS(NB)) bus ();

    assign bus.scl_in   = m_scl;
    assign bus.sda_in_t = m_sdat;
    assign bus.sda_i    = ~bus.sda_oe_o & ~slave_low;

    i2c_merger_n #(
        .NBUS(NB), .SYNC_STAGES(2), .RESET_MASK(3'b111), .CLR_HALF(CH), .CLR_PULSES(9)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .mask_i(mask_i), .mask_o(mask_o), .busy_o(busy_o),
        .clr_req_i(clr_req), .clr_busy_o(clr_busy), .clr_fail_o(clr_fail)
    );

    always #5 clk = ~clk;

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mask_i = 3'b010; m_scl = 1'b1; m_sdat = 1'b0;
        slave_low = '0; clr_req = 1'b0;
        tick(3);
        n_checks++;
        if (bus.scl_oe_o !== 3'b000 || bus.sda_oe_o !== 3'b000 || bus.sda_in_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_pads: scl_oe=%b sda_oe=%b sda_in_o=%b, want 000 000 1",
                     bus.scl_oe_o, bus.sda_oe_o, bus.sda_in_o);
        end
        n_checks++;
        if (mask_o !== 3'b111 || busy_o !== 1'b0 || clr_busy !== 1'b0 || clr_fail !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: mask=%b busy=%b clr_busy=%b clr_fail=%b, want 111 0 0 0",
                     mask_o, busy_o, clr_busy, clr_fail);
        end
        m_sdat = 1'b1; mask_i = 3'b111; rst = 1'b0;
        tick(4);
    endtask

    task automatic test_forward();
        logic [1:0] seq[$];
        logic [1:0] prevpair;
        logic [7:0] addr;
        logic [2:0] exp_scl;
        logic [2:0] exp_sda;
        addr = 8'h62;
        seq.push_back(2'b11); seq.push_back(2'b11);
        seq.push_back(2'b10); seq.push_back(2'b10);
        seq.push_back(2'b00);
        for (int j = 7; j >= 0; j--) begin
            seq.push_back({1'b0, addr[j]}); seq.push_back({1'b0, addr[j]});
            seq.push_back({1'b1, addr[j]}); seq.push_back({1'b1, addr[j]});
        end
        prevpair = 2'b11;
        for (int i = 0; i < seq.size(); i++) begin
            m_scl = seq[i][1]; m_sdat = seq[i][0];
            tick();
            exp_scl = 3'b111 & ~{3{prevpair[1]}};
            exp_sda = 3'b111 & ~{3{prevpair[0]}};
            n_checks++;
            if (bus.scl_oe_o !== exp_scl || bus.sda_oe_o !== exp_sda) begin
                n_fail++;
                $display("[TB] FAIL forward step %0d: scl_oe=%b sda_oe=%b, want %b %b",
                         i, bus.scl_oe_o, bus.sda_oe_o, exp_scl, exp_sda);
            end
            prevpair = seq[i];
        end
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_busy: busy=%b, want 1", busy_o);
        end
        m_scl = 1'b0; tick();
        m_sdat = 1'b1; tick(6);
        slave_low = 3'b010;
        tick(2);
        n_checks++;
        if (bus.sda_in_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ack_early: sda_in_o=%b, want 1", bus.sda_in_o);
        end
        tick();
        n_checks++;
        if (bus.sda_in_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ack_latency: sda_in_o=%b, want 0", bus.sda_in_o);
        end
        m_scl = 1'b1; tick(2);
        m_scl = 1'b0; tick();
        slave_low = '0; m_sdat = 1'b0; tick(2);
        m_scl = 1'b1; tick(2);
        m_sdat = 1'b1; tick(3);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stop_idle: busy=%b, want 0", busy_o);
        end
    endtask

    task automatic test_mask_change();
        m_sdat = 1'b0; tick(2);
        m_scl = 1'b0; tick();
        mask_i = 3'b001;
        tick(3);
        n_checks++;
        if (mask_o !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL mask_held: mask=%b, want 111", mask_o);
        end
        m_sdat = 1'b1; tick();
        m_scl = 1'b1; tick(2);
        m_scl = 1'b0; tick();
        m_sdat = 1'b0; tick();
        m_scl = 1'b1; tick(2);
        m_sdat = 1'b1;
        tick(2);
        n_checks++;
        if (busy_o !== 1'b0 || mask_o !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL mask_at_stop: busy=%b mask=%b, want 0 111", busy_o, mask_o);
        end
        tick();
        n_checks++;
        if (mask_o !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL mask_after_stop: mask=%b, want 001", mask_o);
        end
        m_scl = 1'b0; tick(2);
        n_checks++;
        if (bus.scl_oe_o !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL mask_bus0_low: scl_oe=%b, want 001", bus.scl_oe_o);
        end
        m_scl = 1'b1; tick(2);
        n_checks++;
        if (bus.scl_oe_o !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL mask_bus0_high: scl_oe=%b, want 000", bus.scl_oe_o);
        end
        slave_low = 3'b100; tick(5);
        n_checks++;
        if (bus.sda_in_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL masked_slave: sda_in_o=%b, want 1", bus.sda_in_o);
        end
        slave_low = 3'b001; tick(4);
        n_checks++;
        if (bus.sda_in_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL enabled_slave: sda_in_o=%b, want 0", bus.sda_in_o);
        end
        slave_low = '0; tick(4);
    endtask

    task automatic test_clear_ok();
        int pulses, last_rel, period_bad, sa, sb, cyc;
        logic [2:0] prev_scl;
        mask_i = 3'b111; tick(2);
        n_checks++;
        if (mask_o !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL mask_idle_apply: mask=%b, want 111", mask_o);
        end
        slave_low = 3'b010; tick(4);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        n_checks++;
        if (clr_busy !== 1'b1 || bus.scl_oe_o !== 3'b111 || bus.sda_in_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_start: clr_busy=%b scl_oe=%b sda_in_o=%b, want 1 111 1",
                     clr_busy, bus.scl_oe_o, bus.sda_in_o);
        end
        pulses = 0; last_rel = -1; period_bad = 0; sa = 0; sb = 0; cyc = 0;
        prev_scl = 3'b111;
        while (clr_busy === 1'b1 && cyc < 400) begin
            tick(); cyc++;
            if (prev_scl == 3'b111 && bus.scl_oe_o == 3'b000 && bus.sda_oe_o == 3'b000) begin
                pulses++;
                if (last_rel >= 0 && cyc - last_rel != 2 * CH) period_bad++;
                last_rel = cyc;
                if (pulses == 4) slave_low = '0;
            end
            if (bus.scl_oe_o == 3'b111 && bus.sda_oe_o == 3'b111) sa++;
            if (bus.scl_oe_o == 3'b000 && bus.sda_oe_o == 3'b111) sb++;
            prev_scl = bus.scl_oe_o;
        end
        n_checks++;
        if (clr_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_ok_timeout: clr_busy=%b after %0d cycles, want 0", clr_busy, cyc);
        end
        n_checks++;
        if (pulses != 4 || period_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL clear_ok_pulses: pulses=%0d bad_periods=%0d, want 4 0", pulses, period_bad);
        end
        n_checks++;
        if (sa != CH || sb != CH) begin
            n_fail++;
            $display("[TB] FAIL clear_ok_stop: sa=%0d sb=%0d cycles, want %0d %0d", sa, sb, CH, CH);
        end
        n_checks++;
        if (clr_fail !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_ok_fail: clr_fail=%b, want 0", clr_fail);
        end
        tick(2);
    endtask

    task automatic test_clear_fail();
        int pulses, stop_cyc, cyc;
        logic [2:0] prev_scl;
        slave_low = 3'b010; tick(4);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        pulses = 0; stop_cyc = 0; cyc = 0; prev_scl = 3'b111;
        while (clr_busy === 1'b1 && cyc < 400) begin
            tick(); cyc++;
            if (prev_scl == 3'b111 && bus.scl_oe_o == 3'b000) pulses++;
            if (bus.sda_oe_o != 3'b000) stop_cyc++;
            prev_scl = bus.scl_oe_o;
        end
        n_checks++;
        if (clr_busy !== 1'b0 || pulses != 9 || stop_cyc != 0) begin
            n_fail++;
            $display("[TB] FAIL clear_fail_seq: clr_busy=%b pulses=%0d stop_cycles=%0d, want 0 9 0",
                     clr_busy, pulses, stop_cyc);
        end
        n_checks++;
        if (clr_fail !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_fail_flag: clr_fail=%b, want 1", clr_fail);
        end
        tick(2);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        n_checks++;
        if (clr_fail !== 1'b0 || clr_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL clear_fail_rearm: clr_fail=%b clr_busy=%b, want 0 1", clr_fail, clr_busy);
        end
        slave_low = '0; cyc = 0;
        while (clr_busy === 1'b1 && cyc < 200) begin
            tick(); cyc++;
        end
        n_checks++;
        if (clr_busy !== 1'b0 || clr_fail !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_rearm_end: clr_busy=%b clr_fail=%b, want 0 0", clr_busy, clr_fail);
        end
        tick(2);
    endtask

    task automatic test_dropped_requests();
        int dur;
        m_sdat = 1'b0; tick(2);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drop_busy_start: busy=%b, want 1", busy_o);
        end
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        tick(3);
        n_checks++;
        if (clr_busy !== 1'b0 || bus.sda_oe_o !== 3'b111 || bus.scl_oe_o !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL drop_when_busy: clr_busy=%b sda_oe=%b scl_oe=%b, want 0 111 000",
                     clr_busy, bus.sda_oe_o, bus.scl_oe_o);
        end
        m_sdat = 1'b1; tick(3);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drop_busy_stop: busy=%b, want 0", busy_o);
        end
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        dur = 1;
        tick(4); dur += 4;
        clr_req = 1'b1; tick(); clr_req = 1'b0; dur++;
        while (clr_busy === 1'b1 && dur < 200) begin
            tick(); dur++;
        end
        n_checks++;
        if (dur != 5 * CH + 1) begin
            n_fail++;
            $display("[TB] FAIL drop_during_clear: clear ended after %0d cycles, want %0d", dur, 5 * CH + 1);
        end
        tick(2);
    endtask

    task automatic test_reset_mid_clear();
        int cyc;
        mask_i = 3'b011; tick(3);
        slave_low = 3'b010; tick(3);
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        cyc = 0;
        while (!(bus.scl_oe_o == 3'b000 && clr_busy === 1'b1) && cyc < 40) begin
            tick(); cyc++;
        end
        n_checks++;
        if (bus.scl_oe_o !== 3'b000 || clr_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_reach_hi: scl_oe=%b clr_busy=%b, want 000 1", bus.scl_oe_o, clr_busy);
        end
        tick(2);
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if (bus.scl_oe_o !== 3'b000 || bus.sda_oe_o !== 3'b000 || bus.sda_in_o !== 1'b1 ||
            mask_o !== 3'b111 || clr_busy !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_clear: scl_oe=%b sda_oe=%b sda_in_o=%b mask=%b clr_busy=%b busy=%b, want 000 000 1 111 0 0",
                     bus.scl_oe_o, bus.sda_oe_o, bus.sda_in_o, mask_o, clr_busy, busy_o);
        end
        tick();
        n_checks++;
        if (mask_o !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL mask_after_rst: mask=%b, want 011", mask_o);
        end
        slave_low = '0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_mask_change();
        test_clear_ok();
        test_clear_fail();
        test_dropped_requests();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
